mii_rx_framer: RTL

Parametrised successor to the team's RMII byte receiver, generalised to RMII (2-bit) or MII (4-bit) nibble width. It hunts for the SFD and assembles bytes LSB-first. It delimits each frame with start/end strobes, counts the frame length, and checks the Ethernet FCS (CRC-32). It sits between the PHY pins, retimed to clk, and the MAC receive buffer.

---
 rtl/mii_rx_framer_if.sv | 27 ++
 rtl/mii_rx_framer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mii_rx_framer_if.sv
// PHY-side receive bus of mii_rx_framer: retimed PHY pins in, framed byte stream out.
// master = PHY/retimer side, slave = framer side.
interface mii_rx_framer_if #(
    parameter int DATA_W = 2,
    parameter int LEN_W  = 11
);
    logic              rx_er;
    logic [DATA_W-1:0] rx_d;
    logic              crs_dv;
    logic [7:0]        data_o;
    logic              valid_o;
    logic              sof_o;
    logic              eof_o;
    logic [LEN_W-1:0]  len_o;
    logic              err_o;
    logic              fcs_ok_o;

    modport master (
        output rx_er, rx_d, crs_dv,
        input  data_o, valid_o, sof_o, eof_o, len_o, err_o, fcs_ok_o
    );

    modport slave (
        input  rx_er, rx_d, crs_dv,
        output data_o, valid_o, sof_o, eof_o, len_o, err_o, fcs_ok_o
    );
endinterface

// File: rtl/mii_rx_framer.sv
// RMII/MII receive framer: SFD hunt, LSB-first byte assembly, frame delimiting,
// length counting and CRC-32 residue check.
module mii_rx_framer #(
    parameter int DATA_W    = 2,
    parameter int CHECK_FCS = 1,
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518,
    parameter int LEN_W     = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    mii_rx_framer_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HUNT = 3'd1;
    localparam logic [2:0] S_RECV = 3'd2;
    localparam logic [2:0] S_DROP = 3'd3;
    localparam logic [2:0] S_END  = 3'd4;

    localparam int               BEATS     = 8 / DATA_W;
    localparam logic [1:0]       BEAT_LAST = 2'(BEATS - 1);
    localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MIN_L     = LEN_W'(MIN_LEN);

    logic [2:0]       r_state;
    logic [7:0]       r_sr;
    logic [1:0]       r_beat;
    logic [LEN_W-1:0] r_len;
    logic [31:0]      r_crc;
    logic             r_err;
    logic             r_sof_seen;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_sof;
    logic             r_eof;
    logic [LEN_W-1:0] r_len_o;
    logic             r_err_o;
    logic             r_fcs_ok;

    logic [7:0]       w_sr_next;
    logic             w_byte_done;
    logic             w_fcs_ok;
    logic             w_err_sum;
    logic [LEN_W-1:0] w_len_inc;

    // Reflected CRC-32, one byte LSB first; the caller keeps the register uninverted.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        end
        return r;
    endfunction

    assign w_sr_next   = {bus.rx_d, r_sr[7:DATA_W]};
    assign w_byte_done = (r_beat == BEAT_LAST);
    assign w_fcs_ok    = (CHECK_FCS != 0) && (r_crc == 32'hDEBB20E3);
    assign w_len_inc   = (r_len == {LEN_W{1'b1}}) ? r_len : r_len + 1'b1;
    assign w_err_sum   = r_err || (r_beat != 2'd0) || (r_len < MIN_L) ||
                         ((CHECK_FCS != 0) && !w_fcs_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sr       <= 8'h00;
            r_beat     <= 2'd0;
            r_len      <= '0;
            r_crc      <= 32'hFFFFFFFF;
            r_err      <= 1'b0;
            r_sof_seen <= 1'b0;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_len_o    <= '0;
            r_err_o    <= 1'b0;
            r_fcs_ok   <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_sof    <= 1'b0;
            r_eof    <= 1'b0;
            r_len_o  <= '0;
            r_err_o  <= 1'b0;
            r_fcs_ok <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sof_seen <= 1'b0;
                    if (bus.crs_dv) begin
                        r_sr    <= w_sr_next;
                        r_state <= S_HUNT;
                    end
                end
                S_HUNT: begin
                    if (!bus.crs_dv) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_sr <= w_sr_next;
                        if (w_sr_next == 8'hD5 && !bus.rx_er) begin
                            r_state    <= S_RECV;
                            r_beat     <= 2'd0;
                            r_len      <= '0;
                            r_crc      <= 32'hFFFFFFFF;
                            r_err      <= 1'b0;
                            r_sof_seen <= 1'b0;
                        end else if (bus.rx_er) begin
                            r_state <= S_DROP;
                        end
                    end
                end
                S_RECV: begin
                    // Carrier fall takes priority: rx_er without crs_dv is meaningless.
                    if (!bus.crs_dv) begin
                        r_state  <= S_END;
                        r_eof    <= 1'b1;
                        r_len_o  <= r_len;
                        r_err_o  <= w_err_sum;
                        r_fcs_ok <= w_fcs_ok;
                    end else if (bus.rx_er) begin
                        r_err   <= 1'b1;
                        r_state <= S_DROP;
                    end else begin
                        r_sr <= w_sr_next;
                        if (!w_byte_done) begin
                            r_beat <= r_beat + 2'd1;
                        end else begin
                            r_beat <= 2'd0;
                            if (r_len == MAX_L) begin
                                r_err   <= 1'b1;
                                r_state <= S_DROP;
                            end else begin
                                r_data     <= w_sr_next;
                                r_valid    <= 1'b1;
                                r_sof      <= !r_sof_seen;
                                r_sof_seen <= 1'b1;
                                r_len      <= w_len_inc;
                                r_crc      <= crc32_byte(r_crc, w_sr_next);
                            end
                        end
                    end
                end
                S_DROP: begin
                    // A frame that never produced sof_o vanishes without an eof_o.
                    if (!bus.crs_dv) begin
                        if (r_sof_seen) begin
                            r_state  <= S_END;
                            r_eof    <= 1'b1;
                            r_len_o  <= r_len;
                            r_err_o  <= w_err_sum;
                            r_fcs_ok <= w_fcs_ok;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_END: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_o   = r_data;
    assign bus.valid_o  = r_valid;
    assign bus.sof_o    = r_sof;
    assign bus.eof_o    = r_eof;
    assign bus.len_o    = r_len_o;
    assign bus.err_o    = r_err_o;
    assign bus.fcs_ok_o = r_fcs_ok;
endmodule
